// File: rtl/sdrc_wb_arbiter.sv
// sdrc_wb_arbiter
// Round-robin Wishbone arbiter in front of a single SDRAM controller slave.
// One requester at a time owns the slave for its whole bus cycle (m_cyc_i
// high). The owner's control/address/data fields are muxed combinationally
// onto the slave port, and the slave's ack/data are routed back to it. A
// stalled strobe (no ack) for TIMEOUT cycles aborts the owner with a
// one-cycle m_err_o pulse, and the arbiter parks in an error state until the
// owner drops m_cyc_i.
//
// Ports
//   sys_clk, RESETN          clock, asynchronous active-low reset
//   sdr_init_done            new grants are blocked while low
//   m_cyc_i/m_stb_i/m_we_i   per-requester controls, bit i = requester i
//   m_sel_i/m_adr_i/m_dat_i  flattened per-requester fields, slice i = requester i
//   m_dat_o                  read data broadcast to all requesters
//   m_ack_o/m_err_o          per-requester ack / error
//   s_*_o, s_dat_i, s_ack_i  slave-side Wishbone port
//   gnt_o                    one-hot current owner, zero when none
module sdrc_wb_arbiter #(
  parameter int unsigned NUM_M   = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 26,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  sys_clk,
  input  logic                  RESETN,
  input  logic                  sdr_init_done,
  input  logic [NUM_M-1:0]      m_cyc_i,
  input  logic [NUM_M-1:0]      m_stb_i,
  input  logic [NUM_M-1:0]      m_we_i,
  input  logic [NUM_M*DW/8-1:0] m_sel_i,
  input  logic [NUM_M*AW-1:0]   m_adr_i,
  input  logic [NUM_M*DW-1:0]   m_dat_i,
  output logic [DW-1:0]         m_dat_o,
  output logic [NUM_M-1:0]      m_ack_o,
  output logic [NUM_M-1:0]      m_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [DW/8-1:0]       s_sel_o,
  output logic [AW-1:0]         s_adr_o,
  output logic [DW-1:0]         s_dat_o,
  input  logic [DW-1:0]         s_dat_i,
  input  logic                  s_ack_i,
  output logic [NUM_M-1:0]      gnt_o
);

  localparam int unsigned IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int unsigned SW = DW / 8;
  // Compare against TIMEOUT-1 so the abort fires on the TIMEOUT-th stalled cycle.
  localparam logic [9:0] ToLast = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StOwn, StErr} state_e;

  state_e          state_q, state_d;
  // Index of the most recent winner; doubles as the current owner index.
  logic [IW-1:0]   last_q, last_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [9:0]      cnt_q, cnt_d;

  logic            own;
  logic            sel_cyc, sel_stb, sel_we;
  logic [SW-1:0]   sel_sel;
  logic [AW-1:0]   sel_adr;
  logic [DW-1:0]   sel_dat;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic            timeout;

  assign own = (state_q == StOwn);

  // Owner slice select.
  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    sel_we  = 1'b0;
    sel_sel = '0;
    sel_adr = '0;
    sel_dat = '0;
    for (int unsigned i = 0; i < NUM_M; i++) begin
      if (last_q == IW'(i)) begin
        sel_cyc = m_cyc_i[i];
        sel_stb = m_stb_i[i];
        sel_we  = m_we_i[i];
        sel_sel = m_sel_i[i*SW +: SW];
        sel_adr = m_adr_i[i*AW +: AW];
        sel_dat = m_dat_i[i*DW +: DW];
      end
    end
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    logic [IW-1:0] cand;
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int unsigned off = 1; off <= NUM_M; off++) begin
      cand = IW'((32'(last_q) + off) % NUM_M);
      if (!win_found && m_cyc_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // An ack on the deadline cycle wins over the abort.
  assign timeout = own && sel_cyc && sel_stb && !s_ack_i && (cnt_q == ToLast);

  // State register.
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= StIdle;
      last_q  <= IW'(NUM_M - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (sdr_init_done && win_found) begin
          state_d = StOwn;
          last_d  = win_idx;
          gnt_d   = NUM_M'(1) << win_idx;
        end
      end
      StOwn: begin
        if (!sel_cyc) begin
          state_d = StIdle;
          gnt_d   = '0;
        end else if (timeout) begin
          state_d = StErr;
        end else if (sel_stb && !s_ack_i) begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      StErr: begin
        if (!sel_cyc) begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  // Outputs: the slave port is only driven while owning; ack/data outside
  // that window are dropped.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_dat_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (own) begin
      s_cyc_o = sel_cyc;
      s_stb_o = sel_stb;
      s_we_o  = sel_we;
      s_sel_o = sel_sel;
      s_adr_o = sel_adr;
      s_dat_o = sel_dat;
      m_dat_o = s_dat_i;
      m_ack_o = s_ack_i ? gnt_q : '0;
      m_err_o = timeout ? gnt_q : '0;
    end
  end

  assign gnt_o = gnt_q;

endmodule

// File: doc/sdrc_wb_arbiter.md
SDRC_WB_ARBITER -- requirements
Module: sdrc_wb_arbiter

Interface
REQ-001 Parameter NUM_M, default 4, number of Wishbone requesters (2..8).
REQ-002 Parameter DW, default 32, application data width.
REQ-003 Parameter AW, default 26, application address width.
REQ-004 Parameter TIMEOUT, default 255, cycles with stb high and no ack before abort (1..1023).
REQ-005 Port sys_clk  input  1  sole clock; all logic on rising edge.
REQ-006 Port RESETN  input  1  asynchronous, active-low reset.
REQ-007 Port sdr_init_done  input  1  SDRAM init complete; no grant while low.
REQ-008 Ports m_cyc_i, m_stb_i, m_we_i  input  NUM_M each  per-requester Wishbone controls, bit i = requester i.
REQ-009 Ports m_sel_i NUM_M*DW/8, m_adr_i NUM_M*AW, m_dat_i NUM_M*DW  input  flattened per-requester fields, slice i = requester i.
REQ-010 Port m_dat_o  output  DW  read data, broadcast to all requesters.
REQ-011 Ports m_ack_o, m_err_o  output  NUM_M each  per-requester ack / error.
REQ-012 Ports s_cyc_o, s_stb_o, s_we_o  output  1 each; s_sel_o DW/8; s_adr_o AW; s_dat_o DW  toward SDRAM controller slave.
REQ-013 Ports s_dat_i  input  DW; s_ack_i  input  1  from SDRAM controller slave.
REQ-014 Port gnt_o  output  NUM_M  one-hot current owner, all-zero when no owner.

Function
REQ-015 FSM states SHALL be IDLE, OWN, ERR.
REQ-016 IDLE: when sdr_init_done=1 and any m_cyc_i bit high, SHALL register a grant and enter OWN on that edge.
REQ-017 Arbitration SHALL be round-robin: search starts at index last+1 modulo NUM_M; first requester with m_cyc_i high wins.
REQ-018 last SHALL update to the winner index on each grant.
REQ-019 OWN: s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o SHALL combinationally mirror the owner's slice; non-owner slices ignored.
REQ-020 Grant latency: owner's first s_cyc_o SHALL appear the cycle after its m_cyc_i rises (if arbiter idle).
REQ-021 m_ack_o[owner] SHALL equal s_ack_i while in OWN; all other ack bits 0; m_dat_o SHALL equal s_dat_i.
REQ-022 Grant SHALL be held for the full cycle (multiple stb/ack beats allowed); OWN -> IDLE when m_cyc_i[owner] is low; no re-grant in that same edge.
REQ-023 Timeout counter (10 bits) SHALL clear on s_ack_i or when s_stb_o low, increment otherwise in OWN.
REQ-024 Counter reaching TIMEOUT SHALL: pulse m_err_o[owner] for one cycle, drive s_cyc_o/s_stb_o low the next cycle, enter ERR.
REQ-025 ERR: slave outputs deasserted, gnt_o held; -> IDLE when m_cyc_i[owner] low.
REQ-026 s_ack_i arriving on the same edge the timeout fires SHALL win: ack passes, counter clears, no err.
REQ-027 s_ack_i received outside OWN SHALL be discarded.
REQ-028 sdr_init_done falling mid-OWN SHALL NOT revoke the grant; it only blocks new grants.

Reset
REQ-029 RESETN low SHALL asynchronously force state=IDLE, last=NUM_M-1, counter=0, gnt_o=0.
REQ-030 During reset all outputs SHALL be 0: s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, m_ack_o, m_err_o, m_dat_o, gnt_o.
REQ-031 RESETN assertion mid-OWN SHALL drop s_cyc_o immediately without err or ack.

Verification
REQ-032 sdr_init_done=0, m_cyc_i=4'b0001 for 20 cycles -> gnt_o=0, s_cyc_o=0; init_done=1 -> gnt_o=4'b0001 next cycle.
REQ-033 After reset, m_cyc_i=4'b1111 held, each master does one single-beat cycle -> grant order 0,1,2,3,0.
REQ-034 Master 2 owns, 4-beat write burst to adr 0x100..0x103 while master 1 requests -> all 4 acks to master 2 only, master 1 granted after master 2 drops cyc plus one IDLE cycle.
REQ-035 TIMEOUT=8, s_ack_i tied 0, master 0 stb high -> m_err_o[0] pulse on 8th stalled cycle, s_cyc_o low next cycle, ERR until m_cyc_i[0] drops.
REQ-036 s_ack_i asserted exactly on count 8 with TIMEOUT=8 -> m_ack_o[0]=1, m_err_o=0.
REQ-037 RESETN pulsed low during master 3 read -> all outputs 0 within same cycle; post-reset first grant goes to master 0.
